fmap_maxpool2x2: RTL and testbench

FMAP_MAXPOOL2X2 -- requirements
Module: fmap_maxpool2x2

---
 rtl/fmap_maxpool2x2.sv | 99 +++++++++
 tb/tb_fmap_maxpool2x2.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fmap_maxpool2x2.sv
// 2x2 stride-2 max pooling over a raster-order signed feature-map stream.
// One pooled pixel per window, emitted one clock after the window's bottom-right beat.
module fmap_maxpool2x2 #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned IN_COLS    = 10,
    parameter int unsigned IN_ROWS    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int unsigned CW   = $clog2(IN_COLS);
    localparam int unsigned RW   = $clog2(IN_ROWS);
    localparam int unsigned HALF = IN_COLS / 2;
    localparam int unsigned LBW  = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    // One horizontal max per window column, written on even rows, read on odd rows.
    logic [DATA_WIDTH-1:0] lb_q [HALF];
    logic                  lb_we;

    logic                  col_last, row_last;
    logic [LBW-1:0]        col_half;
    logic [DATA_WIDTH-1:0] hmax, lb_rd, pooled;

    assign col_last = (col_q == CW'(IN_COLS - 1));
    assign row_last = (row_q == RW'(IN_ROWS - 1));
    assign col_half = LBW'(col_q >> 1);
    assign lb_rd    = lb_q[col_half];
    assign hmax     = ($signed(pair_q) > $signed(data_in)) ? pair_q : data_in;
    assign pooled   = ($signed(hmax) > $signed(lb_rd)) ? hmax : lb_rd;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                pair_d = data_in;
            end else if (row_q[0]) begin
                data_out_d   = pooled;
                valid_out_d  = 1'b1;
                frame_done_d = col_last && row_last;
            end else begin
                lb_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[col_half] <= hmax;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fmap_maxpool2x2.sv
// Bench for fmap_maxpool2x2 on a 4x4 frame: table-driven frames plus reset and mixed-sign cases,
// checked through an expected-output queue drained by a negedge monitor.
module tb_fmap_maxpool2x2;

    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          frame_done;

    fmap_maxpool2x2 #(
        .DATA_WIDTH(DW),
        .IN_COLS   (4),
        .IN_ROWS   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]        base;
        logic [DW-1:0]        step;
        logic                 alt;
        logic [3:0][DW-1:0]   ex;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fd;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fd_seen = 0;
    int   fd_exp = 0;
    logic [DW-1:0] last_exp = '0;
    bit   final_req = 1'b0;
    bit   final_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_data_out", 32'(data_out), 32'd0);
            chk("reset_valid_out", 32'(valid_out), 32'd0);
            chk("reset_frame_done", 32'(frame_done), 32'd0);
            last_exp = '0;
        end else if (valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_out", 32'(data_out), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("latency", 32'(cyc), 32'(e.due));
                last_exp = e.data;
            end
            if (frame_done) fd_seen++;
        end else begin
            chk("idle_frame_done", 32'(frame_done), 32'd0);
            chk("hold_data_out", 32'(data_out), 32'(last_exp));
        end
        if (final_req && !final_done) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd0);
            chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));
            final_done = 1'b1;
        end
    end

    task automatic push_exp(input logic [DW-1:0] d, input logic fd);
        exp_t e;
        e.data = d;
        e.fd   = fd;
        e.due  = cyc + 1;
        sb.push_back(e);
        if (fd) fd_exp++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            data_in  = DW'($urandom);
        end
    endtask

    // Window index for a bottom-right beat: (row/2)*2 + col/2 on a 4x4 frame.
    task automatic apply_frame(input logic [15:0][DW-1:0] px, input logic alt,
                               input logic [3:0][DW-1:0] ex);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            data_in  = px[i];
            if (((i / 4) % 2 == 1) && (i % 2 == 1)) begin
                push_exp(ex[(i / 8) * 2 + (i % 4) / 2], 1'(i == 15));
            end
            if (alt) idle(1);
        end
    endtask

    vec_t                 tbl [4];
    logic [15:0][DW-1:0]  px;
    logic [3:0][DW-1:0]   ex;

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;

        tbl[0] = '{base: 24'd0, step: 24'd1, alt: 1'b0,
                   ex: {24'd15, 24'd13, 24'd7, 24'd5}};
        tbl[1] = '{base: 24'd15, step: 24'hFFFFFF, alt: 1'b0,
                   ex: {24'd5, 24'd7, 24'd13, 24'd15}};
        tbl[2] = '{base: 24'hFFFFFF, step: 24'hFFFFFF, alt: 1'b0,
                   ex: {24'hFFFFF5, 24'hFFFFF7, 24'hFFFFFD, 24'hFFFFFF}};
        tbl[3] = '{base: 24'd0, step: 24'd1, alt: 1'b1,
                   ex: {24'd15, 24'd13, 24'd7, 24'd5}};

        #2 rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;

        // Frames 0 and 1 run back to back with valid held high throughout.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) px[i] = DW'(tbl[t].base + tbl[t].step * DW'(i));
            apply_frame(px, tbl[t].alt, tbl[t].ex);
        end
        idle(3);

        px     = '0;
        px[0]  = 24'h800000;
        px[1]  = 24'h7FFFFF;
        px[4]  = 24'h000000;
        px[5]  = 24'hFFFFFF;
        ex     = {24'd0, 24'd0, 24'd0, 24'h7FFFFF};
        apply_frame(px, 1'b0, ex);
        idle(2);

        // Partial frame, then an asynchronous reset pulse that spans no rising edge.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            data_in  = 24'd100;
            if (i == 5) push_exp(24'd100, 1'b0);
        end
        idle(1);
        @(posedge clk);
        #3 rst = 1'b0;
        #4 rst = 1'b1;

        for (int i = 0; i < 16; i++) px[i] = DW'(i);
        ex = {24'd15, 24'd13, 24'd7, 24'd5};
        apply_frame(px, 1'b0, ex);
        idle(5);

        final_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        if (!final_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL final_check: got not-run, required run");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
